// File: rtl/autosym_pkg.sv
// Shared types and constants for the autosymmetry sweep controller.
package autosym_pkg;

    // Sequencer states: idle, evaluate f(x), evaluate f(x ^ alpha), report.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL_A = 2'd1,
        EVAL_B = 2'd2,
        DONE   = 2'd3
    } autosym_state_t;

    // Default core width (number of function inputs).
    localparam int AUTOSYM_N_DEFAULT = 18;

endpackage

// File: rtl/autosym_result_acc.sv
// Result accumulator for the autosymmetry sweep: latches f(x) from the
// EVAL_A cycle, counts the onset, compares against f(x ^ alpha) in the
// EVAL_B cycle and captures the first failing x.
// Optional feature: AUTOSYM_EARLY_ABORT_EN -- when defined, 'abort' is raised
// on a mismatch so the sequencer can stop the sweep early; otherwise 'abort'
// is tied low and the sweep always completes.
module autosym_result_acc
    import autosym_pkg::*;
#(
    parameter int N = AUTOSYM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         eval_a,
    input  logic         eval_b,
    input  logic         core_y,
    input  logic [N-1:0] x,
    output logic         is_sym,
    output logic [N:0]   onset_cnt,
    output logic [N-1:0] fail_x,
    output logic         abort
);

    logic y_a;
    logic mismatch;

    // f(x) and f(x ^ alpha) differ; only meaningful during EVAL_B.
    assign mismatch = eval_b && (core_y != y_a);

`ifdef AUTOSYM_EARLY_ABORT_EN
    assign abort = mismatch;
`else
    assign abort = 1'b0;
`endif

    // Latch f(x), count onset and capture the first mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_a       <= 1'b0;
            is_sym    <= 1'b0;
            onset_cnt <= '0;
            fail_x    <= '0;
        end else if (clear) begin
            y_a       <= 1'b0;
            is_sym    <= 1'b1;
            onset_cnt <= '0;
            fail_x    <= '0;
        end else begin
            if (eval_a) begin
                y_a <= core_y;
                if (core_y) begin
                    onset_cnt <= onset_cnt + {{N{1'b0}}, 1'b1};
                end
            end
            // Only the first mismatch is recorded; later ones leave fail_x alone.
            if (mismatch && is_sym) begin
                fail_x <= x;
                is_sym <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/autosym_sweep_ctrl.sv
// Autosymmetry sweep controller: exhaustively walks x over all 2^N vectors,
// time-sharing one external combinational core between f(x) and
// f(x ^ alpha), and reports symmetry, onset size and first failing x.
// Optional feature: AUTOSYM_EARLY_ABORT_EN (see autosym_result_acc) stops the
// sweep at the first mismatch.
module autosym_sweep_ctrl
    import autosym_pkg::*;
#(
    parameter int N = AUTOSYM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] alpha,
    output logic [N-1:0] core_x,
    input  logic         core_y,
    output logic         busy,
    output logic         done,
    output logic         is_sym,
    output logic [N:0]   onset_cnt,
    output logic [N-1:0] fail_x
);

    autosym_state_t state;
    logic [N-1:0]   x;
    logic [N-1:0]   x_next;
    logic [N-1:0]   alpha_q;
    logic           last_x;
    logic           accept;
    logic           abort;

    assign accept = (state == IDLE) && start;
    assign last_x = (x == {N{1'b1}});
    assign x_next = x + {{(N-1){1'b0}}, 1'b1};

    autosym_result_acc #(
        .N(N)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .eval_a    (state == EVAL_A),
        .eval_b    (state == EVAL_B),
        .core_y    (core_y),
        .x         (x),
        .is_sym    (is_sym),
        .onset_cnt (onset_cnt),
        .fail_x    (fail_x),
        .abort     (abort)
    );

    // Sequencer: state, x counter, captured alpha and the registered core input.
    // core_x always moves with the state so the core sees each vector for
    // exactly one full cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x       <= '0;
            alpha_q <= '0;
            core_x  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alpha_q <= alpha;
                        x       <= '0;
                        core_x  <= '0;
                        busy    <= 1'b1;
                        state   <= EVAL_A;
                    end
                end
                EVAL_A: begin
                    core_x <= x ^ alpha_q;
                    state  <= EVAL_B;
                end
                EVAL_B: begin
                    // Terminal test precedes the increment so x never wraps.
                    if (last_x || abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x      <= x_next;
                        core_x <= x_next;
                        state  <= EVAL_A;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autosym_sweep_ctrl.sv
// Scoreboard bench for autosym_sweep_ctrl with N=4 and a truth-table core.
module tb_autosym_sweep_ctrl;

    localparam int N = 4;

    typedef struct {
        logic       is_sym;
        logic [4:0] onset;
        logic [3:0] fail_x;
        int         lat;
        longint     start_t;
        logic [3:0] a;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] alpha = '0;
    logic [N-1:0] core_x;
    logic         core_y;
    logic         busy;
    logic         done;
    logic         is_sym;
    logic [N:0]   onset_cnt;
    logic [N-1:0] fail_x;
    logic [15:0]  core_tt = 16'h0000;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    // Behavioural function core: f(x) = truth_table[x].
    assign core_y = core_tt[core_x];

    autosym_sweep_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .alpha     (alpha),
        .core_x    (core_x),
        .core_y    (core_y),
        .busy      (busy),
        .done      (done),
        .is_sym    (is_sym),
        .onset_cnt (onset_cnt),
        .fail_x    (fail_x)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: symmetry defined directly over the truth table.
    function automatic exp_t model(input logic [15:0] tt, input logic [3:0] a);
        exp_t e;
        int   first = -1;
        int   limit;
        int   ones = 0;
        for (int xv = 0; xv < 16; xv++) begin
            if (first < 0 && tt[xv] != tt[xv ^ int'(a)]) first = xv;
        end
`ifdef AUTOSYM_EARLY_ABORT_EN
        limit = (first >= 0) ? first : 15;
`else
        limit = 15;
`endif
        for (int xv = 0; xv <= limit; xv++) ones += int'(tt[xv]);
        e.is_sym  = (first < 0);
        e.onset   = 5'(ones);
        e.fail_x  = (first < 0) ? 4'd0 : 4'(first);
        e.lat     = 2 * (limit + 1) + 1;
        e.start_t = 0;
        e.a       = a;
        return e;
    endfunction

    // Monitor: checks core_x/busy each evaluation cycle and results on done.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e   = q.pop_front();
                idx = int'(($time - e.start_t - 5) / 10);
                check("latency", idx + 1, e.lat);
                check("is_sym", int'(is_sym), int'(e.is_sym));
                check("onset_cnt", int'(onset_cnt), int'(e.onset));
                check("fail_x", int'(fail_x), int'(e.fail_x));
                check("busy_in_done", int'(busy), 0);
            end
        end else if (q.size() > 0 && $time > q[0].start_t) begin
            idx = int'(($time - q[0].start_t - 5) / 10);
            if (idx < q[0].lat - 1) begin
                logic [3:0] xe;
                xe = 4'(idx / 2);
                if (idx % 2 == 1) xe = xe ^ q[0].a;
                check("core_x_seq", int'(core_x), int'(xe));
                check("busy_eval", int'(busy), 1);
            end else begin
                check("done_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    // One sweep; optionally pulse a stray start with another alpha mid-sweep.
    task automatic run_sweep(input logic [15:0] tt, input logic [3:0] a, input int inj_cyc);
        exp_t e;
        bit   got = 0;
        @(posedge clk); #1;
        core_tt = tt;
        alpha   = a;
        start   = 1'b1;
        @(posedge clk);
        e = model(tt, a);
        e.start_t = $time;
        q.push_back(e);
        #1 start = 1'b0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            if (!got && i == inj_cyc) begin
                start = 1'b1;
                alpha = a ^ 4'b0010;
                @(negedge clk);
                if (done) got = 1;
                start = 1'b0;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_x"}, int'(core_x), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_is_sym"}, int'(is_sym), 0);
        check({tag, "_onset"}, int'(onset_cnt), 0);
        check({tag, "_fail_x"}, int'(fail_x), 0);
    endtask

    initial begin
        logic [15:0] tt;
        logic [3:0]  a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        @(posedge clk); #1 rst = 1'b0;

        // f = x0 ^ x1: symmetric under 0011, not under 0001.
        run_sweep(16'h6666, 4'b0011, 0);
        run_sweep(16'h6666, 4'b0001, 0);
        // Full onset with alpha=0: count must reach 16 without overflow.
        run_sweep(16'hFFFF, 4'b0000, 0);
        // Stray start mid-sweep is ignored.
        run_sweep(16'h6666, 4'b0011, 5);

        // Reset at cycle 10 of a sweep abandons it without done.
        @(posedge clk); #1;
        core_tt = 16'h6666;
        alpha   = 4'b0011;
        start   = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        repeat (40) @(negedge clk);
        run_sweep(16'h6666, 4'b0011, 0);

        // Random functions and alphas; half are forced symmetric.
        for (int k = 0; k < 16; k++) begin
            tt = 16'($urandom);
            a  = 4'($urandom_range(0, 15));
            if (k % 2 == 0) begin
                for (int xv = 0; xv < 16; xv++) begin
                    if (xv < (xv ^ int'(a))) tt[xv ^ int'(a)] = tt[xv];
                end
            end
            run_sweep(tt, a, (k % 4 == 1) ? 7 : 0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
